vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 11 +
 rtl/vram_wr_fifo.sv | 47 ++++
 rtl/vram_arbiter.sv | 130 +++++++++++++
 tb/tb_vram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: slot states, I/O port offsets and byte-mask encodings shared by the VRAM arbiter
package vram_pkg;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FILL} slot_t;
    localparam logic [7:0] IO_LO   = 8'd0;
    localparam logic [7:0] IO_HI   = 8'd1;
    localparam logic [7:0] IO_DATA = 8'd2;
    localparam logic [1:0] DS_FULL = 2'b00;
    localparam logic [1:0] DS_LO   = 2'b10;
    localparam logic [1:0] DS_HI   = 2'b01;
    localparam logic [1:0] DS_NONE = 2'b11;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous CPU write FIFO with registered full/empty flags
module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_cnt, w_cnt_nx;
    logic             r_empty, r_full, w_push, w_pop;
    assign w_pop    = i_pop && !r_empty;
    // a pop on the same edge frees the slot a full-FIFO push needs
    assign w_push   = i_push && (!r_full || w_pop);
    assign w_cnt_nx = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign o_dout   = r_mem[r_rp];
    assign o_empty  = r_empty;
    assign o_full   = r_full;
    assign o_drop   = i_push && !w_push;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt   <= w_cnt_nx;
            r_empty <= w_cnt_nx == '0;
            r_full  <= w_cnt_nx == (AW+1)'(DEPTH);
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: 8-cycle slot arbiter sharing SDRAM between display reads, CPU writes and fills
module vram_arbiter
    import vram_pkg::*;
#(
    parameter logic [7:0]  IO_BASE      = 8'h40,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] FILL_LAST    = 16'h07FF,
    parameter int          MAX_READ_RUN = 3
) (
    input  logic        clk64,
    input  logic        reset,
    input  logic        sync,
    input  logic        io_wr,
    input  logic [7:0]  io_addr,
    input  logic [7:0]  io_data,
    input  logic        disp_req,
    input  logic [15:0] disp_addr,
    output logic [15:0] disp_data,
    output logic        disp_valid,
    input  logic        fill_start,
    input  logic [15:0] fill_value,
    output logic        fill_busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic [15:0] sd_addr,
    output logic        sd_we,
    output logic        sd_oe,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_ds,
    input  logic [15:0] sd_dout
);
    slot_t       r_state, w_next;
    logic [15:0] r_vram_addr, r_fill_ptr, r_fill_val, r_sd_addr, r_sd_din, r_disp_data;
    logic        r_fill_busy, r_fill_last, r_overflow, r_sd_we, r_sd_oe, r_disp_valid;
    logic [1:0]  r_sd_ds;
    logic [7:0]  r_run;
    logic        w_push, w_pop, w_drop, w_empty, w_full;
    logic        w_fill_load, w_fill_end, w_busy_eff, w_force_wr, w_we, w_oe;
    logic [15:0] w_ptr_eff, w_val_eff, w_addr, w_din;
    logic [1:0]  w_ds;
    logic [23:0] w_head;
    vram_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
        .clk(clk64), .rst(reset), .i_push(w_push), .i_pop(w_pop),
        .i_din({r_vram_addr, io_data}), .o_dout(w_head),
        .o_empty(w_empty), .o_full(w_full), .o_drop(w_drop)
    );
    assign w_push      = io_wr && io_addr == IO_BASE + IO_DATA;
    assign w_pop       = sync && w_next == S_WRITE;
    // a fill starting on the grant edge is visible to that grant
    assign w_fill_load = fill_start && !r_fill_busy;
    assign w_fill_end  = sync && r_state == S_FILL && r_fill_last;
    assign w_busy_eff  = w_fill_load || (r_fill_busy && !w_fill_end);
    assign w_ptr_eff   = w_fill_load ? '0 : r_fill_ptr;
    assign w_val_eff   = w_fill_load ? fill_value : r_fill_val;
    assign w_force_wr  = !w_empty && r_run >= 8'(MAX_READ_RUN);
    always_comb begin
        w_next = !sync ? r_state :
                 (disp_req && !w_force_wr) ? S_READ :
                 !w_empty ? S_WRITE :
                 w_busy_eff ? S_FILL : S_IDLE;
    end
    always_comb begin
        w_we   = w_next == S_WRITE || w_next == S_FILL;
        w_oe   = w_next == S_READ;
        w_addr = w_next == S_READ ? disp_addr :
                 w_next == S_WRITE ? {1'b0, w_head[23:9]} :
                 w_next == S_FILL ? w_ptr_eff : '0;
        w_din  = w_next == S_WRITE ? {2{w_head[7:0]}} :
                 w_next == S_FILL ? w_val_eff : '0;
        w_ds   = w_next == S_WRITE ? (w_head[8] ? DS_HI : DS_LO) :
                 w_next == S_IDLE ? DS_NONE : DS_FULL;
    end
    always_ff @(posedge clk64) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sd_addr <= '0;
            r_sd_din  <= '0;
            r_sd_we   <= 1'b0;
            r_sd_oe   <= 1'b0;
            r_sd_ds   <= DS_NONE;
            r_run     <= '0;
        end else begin
            r_state <= w_next;
            if (sync) begin
                r_sd_addr <= w_addr;
                r_sd_din  <= w_din;
                r_sd_we   <= w_we;
                r_sd_oe   <= w_oe;
                r_sd_ds   <= w_ds;
                r_run     <= (w_next == S_READ && !w_empty) ? r_run + 8'd1 : '0;
            end
        end
    end
    always_ff @(posedge clk64) begin
        if (reset) begin
            r_vram_addr  <= '0;
            r_overflow   <= 1'b0;
            r_fill_busy  <= 1'b0;
            r_fill_last  <= 1'b0;
            r_fill_ptr   <= '0;
            r_fill_val   <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            if (io_wr && io_addr == IO_BASE + IO_LO) r_vram_addr[7:0] <= io_data;
            else if (io_wr && io_addr == IO_BASE + IO_HI) r_vram_addr[15:8] <= io_data;
            else if (w_push && !w_drop) r_vram_addr <= r_vram_addr + 16'd1;
            r_overflow <= r_overflow || w_drop;
            if (w_fill_end) r_fill_busy <= 1'b0;
            else if (w_fill_load) r_fill_busy <= 1'b1;
            if (w_fill_load) r_fill_val <= fill_value;
            if (sync && w_next == S_FILL) begin
                r_fill_ptr  <= w_ptr_eff == FILL_LAST ? w_ptr_eff : w_ptr_eff + 16'd1;
                r_fill_last <= w_ptr_eff == FILL_LAST;
            end else if (w_fill_load) r_fill_ptr <= '0;
            r_disp_valid <= sync && r_state == S_READ;
            if (sync && r_state == S_READ) r_disp_data <= sd_dout;
        end
    end
    assign sd_addr    = r_sd_addr;
    assign sd_din     = r_sd_din;
    assign sd_we      = r_sd_we;
    assign sd_oe      = r_sd_oe;
    assign sd_ds      = r_sd_ds;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign fill_busy  = r_fill_busy;
    assign fifo_full  = w_full;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a queue-based model
module tb_vram_arbiter;
    localparam logic [15:0] LAST = 16'd3;
    logic        clk64 = 1'b0;
    logic        reset = 1'b1, sync = 1'b0, io_wr = 1'b0, disp_req = 1'b0, fill_start = 1'b0;
    logic [7:0]  io_addr = '0, io_data = '0;
    logic [15:0] disp_addr = '0, fill_value = '0, sd_dout = '0;
    logic [15:0] disp_data, sd_addr, sd_din;
    logic        disp_valid, fill_busy, fifo_full, overflow, sd_we, sd_oe;
    logic [1:0]  sd_ds;
    int          vectors = 0, miscompares = 0;
    int          m_qa[$], m_qd[$];
    int          m_vaddr, m_fill_next, m_fill_val, m_run, m_slot;
    bit          m_ovf, m_busy, m_last;
    logic [15:0] e_addr, e_din, e_disp;
    logic        e_we, e_oe, e_valid;
    logic [1:0]  e_ds;

    vram_arbiter #(.FILL_LAST(LAST)) dut (
        .clk64(clk64), .reset(reset), .sync(sync), .io_wr(io_wr), .io_addr(io_addr),
        .io_data(io_data), .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_valid(disp_valid), .fill_start(fill_start), .fill_value(fill_value),
        .fill_busy(fill_busy), .fifo_full(fifo_full), .overflow(overflow), .sd_addr(sd_addr),
        .sd_we(sd_we), .sd_oe(sd_oe), .sd_din(sd_din), .sd_ds(sd_ds), .sd_dout(sd_dout)
    );

    always #5 clk64 = ~clk64;

    task automatic m_reset();
        m_qa.delete();
        m_qd.delete();
        m_vaddr = 0; m_fill_next = 0; m_fill_val = 0; m_run = 0; m_slot = 0;
        m_ovf = 0; m_busy = 0; m_last = 0;
        e_addr = 0; e_din = 0; e_disp = 0; e_we = 0; e_oe = 0; e_valid = 0; e_ds = 2'b11;
    endtask

    // drives one clock of stimulus, advances the model by the same edge, samples 1 time unit later
    task automatic cycle(input bit s, input bit w, input int a, input int d,
                         input bit dr, input int da, input bit fs, input int fv);
        bit ld, pend;
        int ea;
        sync = s; io_wr = w; io_addr = 8'(a); io_data = 8'(d);
        disp_req = dr; disp_addr = 16'(da); fill_start = fs; fill_value = 16'(fv);
        ld = fs && !m_busy;
        e_valid = s && m_slot == 1;
        if (e_valid) e_disp = sd_dout;
        if (s && m_slot == 3 && m_last) m_busy = 0;
        if (ld) begin m_busy = 1; m_fill_next = 0; m_fill_val = fv; end
        if (s) begin
            pend = m_qa.size() > 0;
            e_we = 0; e_oe = 0; e_addr = 0; e_din = 0; e_ds = 2'b11;
            if (dr && !(pend && m_run >= 3)) begin
                m_slot = 1;
                m_run = pend ? m_run + 1 : 0;
                e_oe = 1; e_addr = 16'(da); e_ds = 2'b00;
            end else begin
                m_run = 0;
                if (pend) begin
                    m_slot = 2;
                    ea = m_qa.pop_front();
                    e_we = 1; e_addr = 16'(ea / 2); e_din = 16'(m_qd.pop_front() * 257);
                    e_ds = (ea % 2 == 1) ? 2'b01 : 2'b10;
                end else if (m_busy) begin
                    m_slot = 3;
                    e_we = 1; e_addr = 16'(m_fill_next); e_din = 16'(m_fill_val); e_ds = 2'b00;
                    m_last = m_fill_next == int'(LAST);
                    if (!m_last) m_fill_next++;
                end else m_slot = 0;
            end
        end
        if (w && a == 'h40) m_vaddr = (m_vaddr & 'hFF00) | (d & 'hFF);
        if (w && a == 'h41) m_vaddr = (m_vaddr & 'hFF) | ((d & 'hFF) << 8);
        if (w && a == 'h42) begin
            if (m_qa.size() < 4) begin
                m_qa.push_back(m_vaddr);
                m_qd.push_back(d & 'hFF);
                m_vaddr = (m_vaddr + 1) % 65536;
            end else m_ovf = 1;
        end
        @(posedge clk64);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int d);
        cycle(0, 1, a, d, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({sd_we, sd_oe, sd_addr, sd_din, sd_ds} !== {2'b00, 32'h0, 2'b11}) begin
            miscompares++;
            $display("FAIL reset_sd: got we=%b oe=%b addr=%h din=%h ds=%b, want 0 0 0000 0000 11",
                     sd_we, sd_oe, sd_addr, sd_din, sd_ds);
        end
        vectors++;
        if ({disp_valid, disp_data, fill_busy, fifo_full, overflow} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_flags: got valid=%b data=%h busy=%b full=%b ovf=%b, want all 0",
                     disp_valid, disp_data, fill_busy, fifo_full, overflow);
        end
    endtask

    task automatic test_cpu_write();
        do_reset();
        wr('h40, 'h34);
        wr('h41, 'h12);
        wr('h42, 'hAB);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({sd_we, sd_oe, sd_addr, sd_din, sd_ds} !== {2'b10, 16'h091A, 16'hABAB, 2'b10}) begin
            miscompares++;
            $display("FAIL cpu_write_even: got we=%b oe=%b addr=%h din=%h ds=%b, want 1 0 091a abab 10",
                     sd_we, sd_oe, sd_addr, sd_din, sd_ds);
        end
        idle(6);
        wr('h42, 'h5C);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({sd_we, sd_addr, sd_din, sd_ds} !== {1'b1, 16'h091A, 16'h5C5C, 2'b01}) begin
            miscompares++;
            $display("FAIL cpu_write_odd: got we=%b addr=%h din=%h ds=%b, want 1 091a 5c5c 01",
                     sd_we, sd_addr, sd_din, sd_ds);
        end
        idle(7);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({sd_we, sd_oe, sd_addr, sd_din, sd_ds} !== {2'b00, 32'h0, 2'b11}) begin
            miscompares++;
            $display("FAIL idle_slot: got we=%b oe=%b addr=%h din=%h ds=%b, want 0 0 0000 0000 11",
                     sd_we, sd_oe, sd_addr, sd_din, sd_ds);
        end
        idle(7);
    endtask

    task automatic test_read();
        do_reset();
        sd_dout = 16'hBEEF;
        cycle(1, 0, 0, 0, 1, 'h0100, 0, 0);
        vectors++;
        if ({sd_oe, sd_we, sd_addr, sd_ds} !== {2'b10, 16'h0100, 2'b00}) begin
            miscompares++;
            $display("FAIL read_slot: got oe=%b we=%b addr=%h ds=%b, want 1 0 0100 00",
                     sd_oe, sd_we, sd_addr, sd_ds);
        end
        for (int i = 0; i < 7; i++) begin
            idle(1);
            vectors++;
            if (disp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL read_early_valid: cycle %0d got valid=%b, want 0", i + 1, disp_valid);
            end
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({disp_valid, disp_data} !== {1'b1, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL read_return: got valid=%b data=%h, want 1 beef", disp_valid, disp_data);
        end
        idle(1);
        vectors++;
        if (disp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_pulse_width: got valid=%b, want 0", disp_valid);
        end
        idle(6);
    endtask

    task automatic test_starvation();
        bit er;
        do_reset();
        for (int i = 0; i < 3; i++) wr('h42, i);
        for (int k = 0; k < 8; k++) begin
            cycle(1, 0, 0, 0, 1, 'h0200, 0, 0);
            er = (k % 4) != 3;
            vectors++;
            if ({sd_oe, sd_we} !== {er, !er}) begin
                miscompares++;
                $display("FAIL starvation slot %0d: got oe=%b we=%b, want %b %b", k, sd_oe, sd_we, er, !er);
            end
            idle(7);
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(7);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr('h42, 'h10 + i);
            vectors++;
            if ({fifo_full, overflow} !== {i >= 3, i == 4}) begin
                miscompares++;
                $display("FAIL overflow_push %0d: got full=%b ovf=%b, want %b %b",
                         i, fifo_full, overflow, i >= 3, i == 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 0, 0, 0, 0);
            idle(7);
        end
        wr('h42, 'h99);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({sd_addr, sd_din, sd_ds, overflow} !== {16'h0002, 16'h9999, 2'b10, 1'b1}) begin
            miscompares++;
            $display("FAIL overflow_addr: got addr=%h din=%h ds=%b ovf=%b, want 0002 9999 10 1",
                     sd_addr, sd_din, sd_ds, overflow);
        end
        idle(7);
    endtask

    task automatic test_push_pop();
        do_reset();
        for (int i = 1; i <= 4; i++) wr('h42, i);
        cycle(1, 1, 'h42, 'h55, 0, 0, 0, 0);
        vectors++;
        if ({sd_we, sd_addr, sd_din, fifo_full, overflow} !== {1'b1, 16'h0, 16'h0101, 2'b10}) begin
            miscompares++;
            $display("FAIL push_pop: got we=%b addr=%h din=%h full=%b ovf=%b, want 1 0000 0101 1 0",
                     sd_we, sd_addr, sd_din, fifo_full, overflow);
        end
        idle(7);
    endtask

    task automatic test_fill();
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 1, 'hAAAA);
        vectors++;
        if ({fill_busy, sd_we, sd_oe, sd_addr, sd_din, sd_ds} !== {3'b110, 16'h0, 16'hAAAA, 2'b00}) begin
            miscompares++;
            $display("FAIL fill_first: got busy=%b we=%b oe=%b addr=%h din=%h ds=%b, want 1 1 0 0000 aaaa 00",
                     fill_busy, sd_we, sd_oe, sd_addr, sd_din, sd_ds);
        end
        idle(3);
        cycle(0, 0, 0, 0, 0, 0, 1, 'h5555);
        idle(3);
        for (int k = 1; k <= 3; k++) begin
            cycle(1, 0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if ({fill_busy, sd_we, sd_addr, sd_din} !== {2'b11, 16'(k), 16'hAAAA}) begin
                miscompares++;
                $display("FAIL fill_slot %0d: got busy=%b we=%b addr=%h din=%h, want 1 1 %h aaaa",
                         k, fill_busy, sd_we, sd_addr, sd_din, 16'(k));
            end
            idle(7);
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({fill_busy, sd_we, sd_ds} !== {2'b00, 2'b11}) begin
            miscompares++;
            $display("FAIL fill_done: got busy=%b we=%b ds=%b, want 0 0 11", fill_busy, sd_we, sd_ds);
        end
        idle(7);
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        sd_dout = 16'h1234;
        cycle(1, 0, 0, 0, 1, 'h0300, 0, 0);
        vectors++;
        if (sd_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_grant: got oe=%b, want 1", sd_oe);
        end
        idle(3);
        reset = 1'b1;
        idle(1);
        vectors++;
        if ({sd_we, sd_oe, sd_addr, sd_din, sd_ds, disp_valid} !== {2'b00, 32'h0, 2'b11, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got we=%b oe=%b addr=%h din=%h ds=%b valid=%b, want 0 0 0000 0000 11 0",
                     sd_we, sd_oe, sd_addr, sd_din, sd_ds, disp_valid);
        end
        reset = 1'b0;
        m_reset();
        idle(3);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (disp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_reset_valid: cycle %0d got valid=%b, want 0", i, disp_valid);
            end
            idle(1);
        end
        idle(4);
    endtask

    task automatic test_random();
        int tbl[7] = '{'h3F, 'h40, 'h41, 'h42, 'h42, 'h42, 'h43};
        bit s, w, dr, fs;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            s  = (n % 8) == 0;
            w  = $urandom_range(0, 5) == 0;
            dr = $urandom_range(0, 1) == 1;
            fs = $urandom_range(0, 59) == 0;
            sd_dout = 16'($urandom);
            cycle(s, w, tbl[$urandom_range(0, 6)], int'($urandom_range(0, 255)), dr,
                  int'($urandom_range(0, 65535)), fs, int'($urandom_range(0, 65535)));
            vectors++;
            if ({sd_we, sd_oe, sd_addr, sd_din, sd_ds, disp_valid, disp_data, fifo_full, overflow, fill_busy} !==
                {e_we, e_oe, e_addr, e_din, e_ds, e_valid, e_disp, m_qa.size() == 4, m_ovf, m_busy}) begin
                miscompares++;
                $display("FAIL random cycle %0d: got we=%b oe=%b addr=%h din=%h ds=%b v=%b data=%h full=%b ovf=%b busy=%b, want %b %b %h %h %b %b %h %b %b %b",
                         n, sd_we, sd_oe, sd_addr, sd_din, sd_ds, disp_valid, disp_data, fifo_full, overflow, fill_busy,
                         e_we, e_oe, e_addr, e_din, e_ds, e_valid, e_disp, m_qa.size() == 4, m_ovf, m_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_read();
        test_starvation();
        test_overflow();
        test_push_pop();
        test_fill();
        test_reset_mid_slot();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
